sha256_msg_padder: RTL and testbench

Upstream feeder for the simplified SHA-256 core. Accepts a message as a byte stream and emits SHA-256 padded 512-bit blocks in exactly the format the core consumes on its 512-bit block input: message bytes MSB-first, 0x80 terminator, zero fill, and a 64-bit big-endian bit length. Handles multi-block messages and inserts the extra length-only block when the padding does not fit.

---
 rtl/sha256_msg_padder.sv | 134 +++++++++++++
 tb/tb_sha256_msg_padder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// Byte-stream to SHA-256 padded 512-bit block converter.
// Block byte i sits at [511-8i -: 8]; message length is appended as a 64-bit big-endian bit count.
//
// state      | meaning
// FILL       | accepting message bytes into the block buffer
// EMIT_MSG   | presenting a non-final block (full, or padding did not fit)
// EMIT_FINAL | presenting the block that carries the length field
// EMIT_EXTRA | presenting the length-only block after a padding overflow
module sha256_msg_padder #(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_final
);
    typedef enum logic [1:0] {FILL, EMIT_MSG, EMIT_FINAL, EMIT_EXTRA} state_t;

    state_t           state, state_nxt;
    logic [511:0]     data, data_nxt;
    logic [5:0]       idx;
    logic [LEN_W-1:0] byte_count, count_inc;
    logic             pad_pending, last_at_63, first;
    logic             accept, handshake;
    logic [63:0]      len_cur, len_inc;

    assign accept    = (state == FILL) && in_valid;
    assign handshake = (state != FILL) && blk_ready;
    assign count_inc = byte_count + LEN_W'(1);
    assign len_cur   = {{(61-LEN_W){1'b0}}, byte_count, 3'b000};
    assign len_inc   = {{(61-LEN_W){1'b0}}, count_inc, 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (in_valid) begin
                    if (in_last) begin
                        state_nxt = (idx <= 6'd54) ? EMIT_FINAL : EMIT_MSG;
                    end else if (idx == 6'd63) begin
                        state_nxt = EMIT_MSG;
                    end
                end
            end
            EMIT_MSG: begin
                if (blk_ready) begin
                    state_nxt = pad_pending ? EMIT_EXTRA : FILL;
                end
            end
            default: begin
                if (blk_ready) begin
                    state_nxt = FILL;
                end
            end
        endcase
    end

    // The buffer is cleared after every block, so zero fill past the terminator comes for free.
    always_comb begin
        data_nxt = data;
        if (accept) begin
            for (int i = 0; i < 64; i++) begin
                if (6'(i) == idx) begin
                    data_nxt[511-8*i -: 8] = in_data;
                end
                if (in_last && (i > 0) && (6'(i-1) == idx)) begin
                    data_nxt[511-8*i -: 8] = 8'h80;
                end
            end
            if (in_last && (idx <= 6'd54)) begin
                data_nxt[63:0] = len_inc;
            end
        end else if (handshake) begin
            data_nxt = '0;
            if ((state == EMIT_MSG) && pad_pending) begin
                data_nxt[511:504] = last_at_63 ? 8'h80 : 8'h00;
                data_nxt[63:0]    = len_cur;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data        <= '0;
            idx         <= '0;
            byte_count  <= '0;
            pad_pending <= 1'b0;
            last_at_63  <= 1'b0;
            first       <= 1'b1;
        end else begin
            data <= data_nxt;
            if (accept) begin
                idx        <= idx + 6'd1;
                byte_count <= count_inc;
                if (in_last) begin
                    pad_pending <= (idx > 6'd54);
                    last_at_63  <= (idx == 6'd63);
                end
            end else if (handshake) begin
                idx <= '0;
                if (state == EMIT_MSG) begin
                    first <= 1'b0;
                end else begin
                    byte_count  <= '0;
                    pad_pending <= 1'b0;
                    last_at_63  <= 1'b0;
                    first       <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = (state == FILL);
    assign blk_valid = (state != FILL);
    assign blk_final = (state == EMIT_FINAL) || (state == EMIT_EXTRA);
    assign blk_first = first;
    assign blk_data  = data;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: table vectors, hand corner cases and random
// messages compared against a padding model built from plain byte queues.
module tb_sha256_msg_padder;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_last;
    logic [7:0]   in_data;
    logic         blk_valid, blk_ready, blk_first, blk_final;
    logic [511:0] blk_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]   msg[$];
    logic [511:0] exp_blocks[$];
    logic [511:0] got_blocks[$];

    typedef struct {
        int          len;
        int          mode;
        int          hold;
        int          exp_nblk;
        logic [15:0] exp_tail;
    } vec_t;
    vec_t vecs[13];

    always #5 clk = ~clk;

    sha256_msg_padder #(.LEN_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_first(blk_first), .blk_final(blk_final)
    );

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic make_msg(input int len, input int mode);
        msg.delete();
        for (int i = 0; i < len; i++) begin
            case (mode)
                1:       msg.push_back((i % 2 == 0) ? 8'h61 : 8'h62);
                2:       msg.push_back((i % 10 == 9) ? 8'h30 : 8'(32'h31 + 32'(i % 10)));
                default: msg.push_back(8'($urandom));
            endcase
        end
    endtask

    // Standard SHA-256 padding over a byte queue, then cut into 64-byte blocks.
    task automatic build_ref();
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] b;
        p = msg;
        bits = 64'(msg.size()) << 3;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        exp_blocks.delete();
        for (int k = 0; k < p.size() / 64; k++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k+j];
            exp_blocks.push_back(b);
        end
    endtask

    task automatic run_msg(input int hold, input string tag);
        int           pos, blk_idx, held, budget, cyc, n, nexp;
        bit           seen, expect_blk;
        logic [511:0] snap_d;
        logic         snap_f, snap_l;
        n = msg.size();
        build_ref();
        nexp = exp_blocks.size();
        got_blocks.delete();
        pos = 0; blk_idx = 0; held = 0; cyc = 0; seen = 0; expect_blk = 0;
        snap_d = '0; snap_f = 1'b0; snap_l = 1'b0;
        budget = 100 + 8 * n + nexp * (hold + 4);
        while (blk_idx < nexp && cyc < budget) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
            if (expect_blk) begin
                chk({tag, " blk_latency"}, 512'(blk_valid), 512'(1));
                expect_blk = 0;
            end
            if (blk_valid) begin
                chk({tag, " in_ready_emit"}, 512'(in_ready), 512'(0));
                if (!seen) begin
                    seen = 1; held = 0;
                    snap_d = blk_data; snap_f = blk_first; snap_l = blk_final;
                    got_blocks.push_back(blk_data);
                    chk($sformatf("%s blk%0d data", tag, blk_idx), blk_data, exp_blocks[blk_idx]);
                    chk($sformatf("%s blk%0d first", tag, blk_idx), 512'(blk_first), 512'(blk_idx == 0));
                    chk($sformatf("%s blk%0d final", tag, blk_idx), 512'(blk_final), 512'(blk_idx == nexp - 1));
                end else begin
                    chk({tag, " stall_data"}, blk_data, snap_d);
                    chk({tag, " stall_first"}, 512'(blk_first), 512'(snap_f));
                    chk({tag, " stall_final"}, 512'(blk_final), 512'(snap_l));
                end
                if (pos < n) begin
                    in_valid = 1'b1; in_data = msg[pos]; in_last = (pos == n - 1);
                end
                if (held >= hold) begin
                    blk_ready = 1'b1; blk_idx++; seen = 0;
                end else begin
                    held++;
                end
            end else if (in_ready && pos < n && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1; in_data = msg[pos]; in_last = (pos == n - 1);
                if (pos % 64 == 63 || pos == n - 1) expect_blk = 1;
                pos++;
            end
        end
        if (blk_idx < nexp) begin
            checks++; errors++;
            $display("FAIL %s timeout got %0d blocks need %0d", tag, blk_idx, nexp);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
        chk({tag, " post_in_ready"}, 512'(in_ready), 512'(1));
        chk({tag, " post_blk_valid"}, 512'(blk_valid), 512'(0));
    endtask

    task automatic push_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"}, 512'(in_ready), 512'(1));
        chk({tag, " blk_valid"}, 512'(blk_valid), 512'(0));
        chk({tag, " blk_data"}, blk_data, 512'(0));
        chk({tag, " blk_first"}, 512'(blk_first), 512'(1));
        chk({tag, " blk_final"}, 512'(blk_final), 512'(0));
    endtask

    initial begin
        logic [511:0] exp;
        logic [511:0] g;
        vecs[0]  = '{10,  2, 0,  1, 16'h0050};
        vecs[1]  = '{51,  1, 0,  1, 16'h0198};
        vecs[2]  = '{55,  0, 0,  1, 16'h01B8};
        vecs[3]  = '{56,  0, 0,  2, 16'h01C0};
        vecs[4]  = '{63,  0, 0,  2, 16'h01F8};
        vecs[5]  = '{64,  0, 0,  2, 16'h0200};
        vecs[6]  = '{65,  0, 0,  2, 16'h0208};
        vecs[7]  = '{1,   0, 0,  1, 16'h0008};
        vecs[8]  = '{119, 0, 1,  2, 16'h03B8};
        vecs[9]  = '{120, 0, 2,  3, 16'h03C0};
        vecs[10] = '{56,  0, 10, 2, 16'h01C0};
        vecs[11] = '{64,  0, 10, 2, 16'h0200};
        vecs[12] = '{130, 0, 3,  3, 16'h0410};

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; blk_ready = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;

        make_msg(10, 2);
        run_msg(0, "digits");
        exp = '0;
        exp[511 -: 80] = 80'h31323334353637383930;
        exp[431 -: 8]  = 8'h80;
        exp[7:0]       = 8'h50;
        g = (got_blocks.size() > 0) ? got_blocks[0] : 'x;
        chk("digits_const", g, exp);

        for (int t = 0; t < 13; t++) begin
            make_msg(vecs[t].len, vecs[t].mode);
            run_msg(vecs[t].hold, $sformatf("vec%0d", t));
            chk($sformatf("vec%0d nblk", t), 512'(got_blocks.size()), 512'(vecs[t].exp_nblk));
            g = (got_blocks.size() > 0) ? got_blocks[got_blocks.size()-1] : 'x;
            chk($sformatf("vec%0d tail", t), 512'(g[15:0]), 512'(vecs[t].exp_tail));
        end

        for (int r = 0; r < 15; r++) begin
            make_msg($urandom_range(1, 150), 0);
            run_msg($urandom_range(0, 3), $sformatf("rand%0d", r));
        end

        // Reset in the middle of a message discards it.
        @(negedge clk);
        push_bytes(30);
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_mid_msg");
        @(negedge clk);
        reset = 1'b0;
        msg = {8'h61, 8'h62, 8'h63};
        run_msg(0, "abc");
        exp = '0;
        exp[511 -: 32] = 32'h61626380;
        exp[7:0]       = 8'h18;
        g = (got_blocks.size() > 0) ? got_blocks[0] : 'x;
        chk("abc_const", g, exp);

        // Reset while a full block is waiting for the core.
        @(negedge clk);
        push_bytes(64);
        chk("emit_before_rst", 512'(blk_valid), 512'(1));
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_mid_emit");
        @(negedge clk);
        reset = 1'b0;
        make_msg(20, 0);
        run_msg(1, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
